// File: rtl/rv_pkg.sv
// Shared definitions for the single-cycle RV32 core and its instruction loader.
package rv_pkg;

  // Canonical no-op: ADDI x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Loader state encoding
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Major opcodes used by the control and immediate-generation logic
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Little-endian completion of a word: the final (most significant) byte
  // joins the three bytes already collected.
  function automatic logic [31:0] le_pack(input logic [7:0]  top_byte,
                                          input logic [23:0] low_bytes);
    return {top_byte, low_bytes};
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Collects the byte-serial image into little-endian 32-bit words.
// word_valid_o/word_o are combinational so the word can be written to RAM
// on the same edge that accepts its final byte.
module byte_packer
  import rv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,        // drop any partial word, restart at byte 0
  input  logic        accept_i,     // byte_i is consumed this cycle
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_idx_o,
  output logic        word_valid_o, // a complete word is available this cycle
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shreg_q,    shreg_d;

  // Next-state: clear dominates, otherwise deposit the byte at its lane
  always_comb begin
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    if (clr_i) begin
      byte_idx_d = 2'd0;
      shreg_d    = 32'h0000_0000;
    end else if (accept_i) begin
      shreg_d[{byte_idx_q, 3'b000} +: 8] = byte_i;
      byte_idx_d = byte_idx_q + 2'd1;
    end else begin
      byte_idx_d = byte_idx_q;
      shreg_d    = shreg_q;
    end
  end

  // Packer state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_idx_q <= 2'd0;
      shreg_q    <= 32'h0000_0000;
    end else begin
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  assign byte_idx_o   = byte_idx_q;
  assign word_valid_o = accept_i & (byte_idx_q == 2'd3);
  assign word_o       = le_pack(byte_i, shreg_q[23:0]);

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-side responder: boots a byte-serial image into instruction RAM,
// then serves zero-latency fetches for the single-cycle core.
module instr_mem_loader
  import rv_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic [31:0]       pc,
  output logic [31:0]       ins,
  output logic              fetch_fault,
  output logic              running,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  // DEPTH in the widened counter domain so it can be compared and stored
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  logic [0:0]      state_q,      state_d;
  logic [ADDR_W:0] wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W:0] word_count_q, word_count_d;
  logic            load_error_q, load_error_d;

  // Instruction RAM; deliberately not reset, word_count gates visibility
  logic [31:0]     mem_q [DEPTH];

  logic            load_ready_s;
  logic            accept_s;
  logic            reload_s;
  logic            last_s;
  logic            packer_clr_s;
  logic [1:0]      byte_idx_s;
  logic            word_valid_s;
  logic [31:0]     word_s;
  logic [ADDR_W-1:0] idx_s;
  logic            fault_s;
  logic [31:0]     ins_s;

  // Once wr_ptr reaches DEPTH no further byte is taken, so RAM cannot overflow
  assign load_ready_s = (state_q == ST_LOAD) && (wr_ptr_q < DEPTH_W);
  assign accept_s     = load_valid & load_ready_s;
  assign last_s       = accept_s & load_last;
  // reload only counts in RUN; any same-cycle byte is not accepted since ready=0
  assign reload_s     = (state_q == ST_RUN) & reload;
  // A final byte always ends the word stream; a partial word is discarded
  assign packer_clr_s = reload_s | last_s;

  byte_packer u_packer (
    .clk_i        (CLOCK_50),
    .rst_i        (RESET),
    .clr_i        (packer_clr_s),
    .accept_i     (accept_s),
    .byte_i       (load_byte),
    .byte_idx_o   (byte_idx_s),
    .word_valid_o (word_valid_s),
    .word_o       (word_s)
  );

  // Loader FSM next-state and bookkeeping for wr_ptr, word_count, load_error
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    load_error_d = load_error_q;
    case (state_q)
      ST_LOAD: begin
        if (word_valid_s) begin
          wr_ptr_d = wr_ptr_q + ONE_W;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (last_s) begin
          state_d = ST_RUN;
          if (byte_idx_s == 2'd3) begin
            word_count_d = wr_ptr_q + ONE_W;
          end else begin
            word_count_d = wr_ptr_q;
            load_error_d = 1'b1;
          end
        end else if (wr_ptr_q == DEPTH_W) begin
          state_d      = ST_RUN;
          word_count_d = DEPTH_W;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (reload_s) begin
          state_d      = ST_LOAD;
          wr_ptr_d     = '0;
          word_count_d = '0;
          load_error_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d      = ST_LOAD;
        wr_ptr_d     = '0;
        word_count_d = '0;
        load_error_d = 1'b0;
      end
    endcase
  end

  // Control registers with asynchronous reset back to an empty LOAD state
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      load_error_q <= load_error_d;
    end
  end

  // RAM write port: a completed word lands at wr_ptr
  always_ff @(posedge CLOCK_50) begin
    if (word_valid_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= word_s;
    end
  end

  assign idx_s = pc[ADDR_W+1:2];

  // Zero-latency fetch; anything not provably loaded returns NOP
  always_comb begin
    fault_s = 1'b0;
    ins_s   = NOP;
    if (state_q == ST_RUN) begin
      fault_s = (pc[1:0] != 2'b00) | (|pc[31:ADDR_W+2]) |
                ({1'b0, idx_s} >= word_count_q);
      if (fault_s) begin
        ins_s = NOP;
      end else begin
        ins_s = mem_q[idx_s];
      end
    end else begin
      fault_s = 1'b0;
      ins_s   = NOP;
    end
  end

  assign load_ready  = load_ready_s;
  assign running     = (state_q == ST_RUN);
  assign load_error  = load_error_q;
  assign word_count  = word_count_q;
  assign ins         = ins_s;
  assign fetch_fault = fault_s;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: boot load, fetch faults, partial
// words, full-depth load, reload and asynchronous reset.
module tb_instr_mem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              CLOCK_50;
  logic              RESET;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic              reload;
  logic [31:0]       pc;
  logic [31:0]       ins;
  logic              fetch_fault;
  logic              running;
  logic              load_error;
  logic [ADDR_W:0]   word_count;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload      (reload),
    .pc          (pc),
    .ins         (ins),
    .fetch_fault (fetch_fault),
    .running     (running),
    .load_error  (load_error),
    .word_count  (word_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // All tasks start and end 1 time unit after a rising edge
  task automatic push(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_byte = b; load_last = last;
    @(posedge CLOCK_50); #1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge CLOCK_50); #1;
    reload = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b need 1", load_ready); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b need 0", running); end
    n_cmp++; if (word_count !== 9'd0) begin n_err++; $display("FAIL reset_wc: got %0d need 0", word_count); end
    n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b need 0", load_error); end
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL reset_ins: got %h need %h", ins, NOP); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b need 0", fetch_fault); end
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
  endtask

  task automatic test_basic_load();
    push(8'h13, 1'b0); push(8'h00, 1'b0); push(8'hA0, 1'b0);
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL basic_running_early: got %b need 0", running); end
    push(8'h00, 1'b1);
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL basic_running: got %b need 1", running); end
    n_cmp++; if (word_count !== 9'd1) begin n_err++; $display("FAIL basic_wc: got %0d need 1", word_count); end
    n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b need 0", load_error); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready: got %b need 0", load_ready); end
  endtask

  task automatic test_fetch();
    pc = 32'h0; #2;
    n_cmp++; if (ins !== 32'h00A00013) begin n_err++; $display("FAIL fetch0_ins: got %h need 00a00013", ins); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL fetch0_fault: got %b need 0", fetch_fault); end
    pc = 32'h4; #2;
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL fetch4_ins: got %h need %h", ins, NOP); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fetch4_fault: got %b need 1", fetch_fault); end
    pc = 32'h2; #2;
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL fetch2_ins: got %h need %h", ins, NOP); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fetch2_fault: got %b need 1", fetch_fault); end
    pc = 32'h400; #2;
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL fetch400_ins: got %h need %h", ins, NOP); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL fetch400_fault: got %b need 1", fetch_fault); end
    @(posedge CLOCK_50); #1;
    pc = 32'h0;
  endtask

  task automatic test_partial();
    pulse_reload();
    for (int i = 1; i <= 6; i++) begin
      logic [7:0] b;
      b = 8'(i);
      push(b, (i == 6));
    end
    n_cmp++; if (word_count !== 9'd1) begin n_err++; $display("FAIL partial_wc: got %0d need 1", word_count); end
    n_cmp++; if (load_error !== 1'b1) begin n_err++; $display("FAIL partial_err: got %b need 1", load_error); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL partial_running: got %b need 1", running); end
    pc = 32'h4; #1;
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL partial_pc4_ins: got %h need %h", ins, NOP); end
    n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL partial_pc4_fault: got %b need 1", fetch_fault); end
    pc = 32'h0; #1;
    n_cmp++; if (ins !== 32'h04030201) begin n_err++; $display("FAIL partial_pc0_ins: got %h need 04030201", ins); end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reload_same_cycle();
    reload = 1'b1; load_valid = 1'b1; load_byte = 8'hAA; load_last = 1'b0;
    @(posedge CLOCK_50); #1;
    reload = 1'b0; load_valid = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reload_running: got %b need 0", running); end
    n_cmp++; if (word_count !== 9'd0) begin n_err++; $display("FAIL reload_wc: got %0d need 0", word_count); end
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL reload_ins: got %h need %h", ins, NOP); end
    n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL reload_err: got %b need 0", load_error); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reload_fault: got %b need 0", fetch_fault); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reload_ready: got %b need 1", load_ready); end
    // If 0xAA had been consumed, this word would be misaligned and flagged
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
    n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL reload_next_err: got %b need 0", load_error); end
    n_cmp++; if (word_count !== 9'd1) begin n_err++; $display("FAIL reload_next_wc: got %0d need 1", word_count); end
    n_cmp++; if (ins !== 32'h44332211) begin n_err++; $display("FAIL reload_next_ins: got %h need 44332211", ins); end
  endtask

  task automatic test_full();
    int accepted;
    accepted = 0;
    pulse_reload();
    for (int i = 0; i < 4*DEPTH+2; i++) begin
      load_valid = 1'b1; load_byte = i[7:0]; load_last = 1'b0;
      if (load_ready === 1'b1) accepted++;
      @(posedge CLOCK_50); #1;
    end
    load_valid = 1'b0;
    n_cmp++; if (accepted !== 4*DEPTH) begin n_err++; $display("FAIL full_accepted: got %0d need %0d", accepted, 4*DEPTH); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b need 0", load_ready); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL full_running: got %b need 1", running); end
    n_cmp++; if (word_count !== 9'd256) begin n_err++; $display("FAIL full_wc: got %0d need 256", word_count); end
    pc = 32'h3FC; #1;
    n_cmp++; if (ins !== 32'hFFFEFDFC) begin n_err++; $display("FAIL full_last_ins: got %h need fffefdfc", ins); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL full_last_fault: got %b need 0", fetch_fault); end
    pc = 32'h0; #1;
    n_cmp++; if (ins !== 32'h03020100) begin n_err++; $display("FAIL full_first_ins: got %h need 03020100", ins); end
    pc = 32'h400; #1;
    n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL full_range_fault: got %b need 1", fetch_fault); end
    pc = 32'h0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_async_reset();
    pulse_reload();
    push(8'h78, 1'b0); push(8'h56, 1'b0);
    #2 RESET = 1'b1; #1;
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b need 1", load_ready); end
    n_cmp++; if (word_count !== 9'd0) begin n_err++; $display("FAIL areset_wc: got %0d need 0", word_count); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL areset_running: got %b need 0", running); end
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    push(8'h78, 1'b0); push(8'h56, 1'b0); push(8'h34, 1'b0); push(8'h12, 1'b1);
    n_cmp++; if (load_error !== 1'b0) begin n_err++; $display("FAIL areset_fresh_err: got %b need 0", load_error); end
    n_cmp++; if (word_count !== 9'd1) begin n_err++; $display("FAIL areset_fresh_wc: got %0d need 1", word_count); end
    n_cmp++; if (ins !== 32'h12345678) begin n_err++; $display("FAIL areset_fresh_ins: got %h need 12345678", ins); end
    // Asynchronous reset while running must drop RUN without waiting for an edge
    #2 RESET = 1'b1; #1;
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL areset_run_running: got %b need 0", running); end
    n_cmp++; if (word_count !== 9'd0) begin n_err++; $display("FAIL areset_run_wc: got %0d need 0", word_count); end
    n_cmp++; if (ins !== NOP) begin n_err++; $display("FAIL areset_run_ins: got %h need %h", ins, NOP); end
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
    reload = 1'b0; pc = 32'h0;
    test_reset();
    test_basic_load();
    test_fetch();
    test_partial();
    test_reload_same_cycle();
    test_full();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
